// File: rtl/turn_input_cond.sv
// Turn-signal input conditioner: two-flop synchronizers, per-channel debounce,
// and a four-state request FSM with registered left/right/chg outputs.
module turn_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    output logic left,
    output logic right,
    output logic chg
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight,
        StHazard
    } state_e;

    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {right_raw, left_raw};

    // Channel 0 is left, channel 1 is right.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic            r_s1;
        logic            r_s2;
        logic            r_deb;
        logic            w_deb_d;
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_deb <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1  <= w_raw[g];
                r_s2  <= r_s1;
                r_deb <= w_deb_d;
                r_cnt <= w_cnt_d;
            end
        end

        // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
        always_comb begin
            w_deb_d = r_deb;
            w_cnt_d = r_cnt;
            if (r_s2 == r_deb) begin
                w_cnt_d = '0;
            end else if (r_cnt == CntLast) begin
                w_deb_d = r_s2;
                w_cnt_d = '0;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end

        assign w_deb[g] = r_deb;
    end

    state_e r_state;
    state_e w_state_d;
    logic   w_dl;
    logic   w_dr;
    logic   r_left;
    logic   r_right;
    logic   r_chg;

    assign w_dl = w_deb[0];
    assign w_dr = w_deb[1];

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_dl && w_dr) begin
                    w_state_d = StHazard;
                end else if (w_dl) begin
                    w_state_d = StLeft;
                end else if (w_dr) begin
                    w_state_d = StRight;
                end
            end
            StLeft: begin
                if (w_dl && w_dr) begin
                    w_state_d = StHazard;
                end else if (!w_dl) begin
                    w_state_d = StIdle;
                end
            end
            StRight: begin
                if (w_dl && w_dr) begin
                    w_state_d = StHazard;
                end else if (!w_dr) begin
                    w_state_d = StIdle;
                end
            end
            StHazard: begin
                if (!(w_dl && w_dr)) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_left  <= (w_state_d == StLeft) || (w_state_d == StHazard);
            r_right <= (w_state_d == StRight) || (w_state_d == StHazard);
            r_chg   <= (w_state_d != r_state);
        end
    end

    assign left  = r_left;
    assign right = r_right;
    assign chg   = r_chg;

endmodule

// File: tb/tb_turn_input_cond.sv
// Bench for turn_input_cond: directed latency/glitch/reset scenarios plus random
// switch activity, all checked against a history-based behavioural model.
module tb_turn_input_cond;

    localparam int unsigned D = 4;
    localparam int MIdle   = 0;
    localparam int MLeft   = 1;
    localparam int MRight  = 2;
    localparam int MHazard = 3;

    logic clk;
    logic reset;
    logic left_raw;
    logic right_raw;
    logic left;
    logic right;
    logic chg;

    int n_total = 0;
    int n_bad   = 0;

    turn_input_cond #(
        .DEBOUNCE_CYCLES(D)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .left     (left),
        .right    (right),
        .chg      (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: synchronizer as a two-sample delay, debounce as "last D
    // synchronized samples all disagree with the level", FSM from the turn rules.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_deb [2];
    bit hist_l[$];
    bit hist_r[$];
    int m_mode = MIdle;
    bit m_chg  = 1'b0;

    function automatic bit run_done(input bit h[$], input bit lvl);
        if (h.size() < D) return 1'b0;
        for (int i = h.size() - D; i < h.size(); i++) begin
            if (h[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int next_mode(input int mode, input bit dl, input bit dr);
        case (mode)
            MIdle:   return (dl && dr) ? MHazard : dl ? MLeft : dr ? MRight : MIdle;
            MLeft:   return (dl && dr) ? MHazard : !dl ? MIdle : MLeft;
            MRight:  return (dl && dr) ? MHazard : !dr ? MIdle : MRight;
            default: return (dl && dr) ? MHazard : MIdle;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        int nm;
        if (!reset) begin
            m_s1   = '{0, 0};
            m_s2   = '{0, 0};
            m_deb  = '{0, 0};
            hist_l.delete();
            hist_r.delete();
            m_mode = MIdle;
            m_chg  = 1'b0;
        end else begin
            nm     = next_mode(m_mode, m_deb[0], m_deb[1]);
            m_chg  = (nm != m_mode);
            m_mode = nm;
            hist_l.push_back(m_s2[0]);
            hist_r.push_back(m_s2[1]);
            if (hist_l.size() > D) void'(hist_l.pop_front());
            if (hist_r.size() > D) void'(hist_r.pop_front());
            if (run_done(hist_l, m_deb[0])) m_deb[0] = !m_deb[0];
            if (run_done(hist_r, m_deb[1])) m_deb[1] = !m_deb[1];
            m_s2 = m_s1;
            m_s1[0] = left_raw;
            m_s1[1] = right_raw;
        end
    end

    always @(negedge clk) begin
        check("mon_left",  left,  (m_mode == MLeft)  || (m_mode == MHazard));
        check("mon_right", right, (m_mode == MRight) || (m_mode == MHazard));
        check("mon_chg",   chg,   m_chg);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rise;
        int n_chg;
        reset     = 1'b0;
        left_raw  = 1'b0;
        right_raw = 1'b0;
        #2;
        check("rst_left",  left,  1'b0);
        check("rst_right", right, 1'b0);
        check("rst_chg",   chg,   1'b0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(10);

        // Single left request: outputs move after edge N+6.
        left_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("lat_left_low", left, 1'b0);
        end
        tick();
        check("lat_left_high", left,  1'b1);
        check("lat_chg",       chg,   1'b1);
        check("lat_right",     right, 1'b0);
        tick();
        check("lat_chg_once",  chg,   1'b0);
        idle_cycles(8);

        // Direction reversal from LEFT goes through one IDLE cycle.
        @(negedge clk);
        left_raw  = 1'b0;
        right_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rev_hold_left", left, 1'b1);
        end
        tick();
        check("rev_idle_left",  left,  1'b0);
        check("rev_idle_right", right, 1'b0);
        check("rev_idle_chg",   chg,   1'b1);
        tick();
        check("rev_right",      right, 1'b1);
        check("rev_right_chg",  chg,   1'b1);
        tick();
        check("rev_chg_end",    chg,   1'b0);
        @(negedge clk);
        right_raw = 1'b0;
        idle_cycles(12);

        // Three-cycle glitch must be swallowed.
        left_raw = 1'b1;
        idle_cycles(3);
        left_raw = 1'b0;
        n_chg = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_chg += int'(chg | left | right);
        end
        check("glitch_quiet", n_chg, 0);

        // Both switches together go straight to HAZARD.
        @(negedge clk);
        left_raw  = 1'b1;
        right_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("haz_low", {left, right}, 2'b00);
        end
        tick();
        check("haz_both", {left, right}, 2'b11);
        check("haz_chg",  chg, 1'b1);
        tick();
        check("haz_chg_end", chg, 1'b0);
        idle_cycles(4);

        // Mid-cycle 15 ns reset pulse while in HAZARD.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_outs", {left, right, chg}, 3'b000);
        #14 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("arst_recover_low", {left, right, chg}, 3'b000);
        end
        tick();
        check("arst_recover_high", {left, right}, 2'b11);
        check("arst_recover_chg",  chg, 1'b1);
        @(negedge clk);
        left_raw  = 1'b0;
        right_raw = 1'b0;
        idle_cycles(12);

        // Per-cycle bouncing, then a settled high level.
        n_chg = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chg += int'(chg);
            left_raw = (i % 2 == 0);
        end
        @(negedge clk);
        n_chg += int'(chg);
        left_raw = 1'b1;
        rise = -1;
        for (int k = 0; k < 14; k++) begin
            tick();
            n_chg += int'(chg);
            if (left && rise < 0) rise = k;
        end
        check("bounce_rise_edge", rise, D + 2);
        check("bounce_chg_count", n_chg, 1);
        @(negedge clk);
        left_raw = 1'b0;
        idle_cycles(12);

        // Random switch activity with occasional asynchronous resets.
        for (int s = 0; s < 300; s++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                #($urandom_range(4, 9)) reset = 1'b1;
            end else begin
                left_raw  = 1'($urandom_range(0, 1));
                right_raw = 1'($urandom_range(0, 1));
                idle_cycles($urandom_range(0, 8));
            end
        end
        idle_cycles(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/turn_input_cond.md
TURN_INPUT_COND -- requirements
Module: turn_input_cond

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive clk cycles a synchronized input must differ from its debounced level before that level changes; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port left_raw  input  1  unsynchronized, bouncy left turn switch.
REQ-005 SHALL have port right_raw  input  1  unsynchronized, bouncy right turn switch.
REQ-006 SHALL have port left  output  1  registered clean left request, drives the tail-light FSM left input.
REQ-007 SHALL have port right  output  1  registered clean right request, drives the tail-light FSM right input.
REQ-008 SHALL have port chg  output  1  registered one-cycle pulse, high for the cycle after any state change.

Function
REQ-009 SHALL pass each raw input through its own two-flop synchronizer (s1 then s2) before any other logic uses it.
REQ-010 SHALL keep per channel a debounced level and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-011 SHALL, per channel and edge: s2 == debounced -> counter cleared to 0; s2 != debounced and counter == DEBOUNCE_CYCLES-1 -> debounced takes s2, counter cleared; otherwise counter increments.
REQ-012 SHALL ignore any synchronized input excursion shorter than DEBOUNCE_CYCLES cycles: no change to debounced, left, right or chg.
REQ-013 SHALL implement a 4-state machine IDLE, LEFT, RIGHT, HAZARD on debounced levels dl, dr.
REQ-014 SHALL transition from IDLE: dl&!dr -> LEFT; !dl&dr -> RIGHT; dl&dr -> HAZARD; else stay.
REQ-015 SHALL transition from LEFT: dl&dr -> HAZARD; !dl -> IDLE (including !dl&dr, so a direction reversal passes through one IDLE cycle); else stay.
REQ-016 SHALL transition from RIGHT symmetrically: dl&dr -> HAZARD; !dr -> IDLE (including dl&!dr); else stay.
REQ-017 SHALL transition from HAZARD: dl&dr -> stay; any other combination -> IDLE.
REQ-018 SHALL drive left = 1 in LEFT or HAZARD only and right = 1 in RIGHT or HAZARD only, both as registered state decode with no combinational path from inputs.
REQ-019 SHALL assert chg for exactly one cycle following each edge at which state changed; back-to-back changes give consecutive chg cycles.
REQ-020 SHALL have latency: raw held stable from before edge N with all prior activity settled -> left/right update after edge N+2+DEBOUNCE_CYCLES (direct IDLE entry/exit).
REQ-021 SHALL handle simultaneous debounced changes on both channels in the same cycle as a single input combination per REQ-014..017 (e.g. IDLE with dl&dr -> HAZARD directly).

Reset
REQ-022 SHALL, while reset = 0, immediately force s1, s2, debounced levels and counters to 0, state to IDLE, left = 0, right = 0, chg = 0, regardless of clk.
REQ-023 SHALL, on reset rising mid-operation, resume from the REQ-022 values with no chg pulse for the reset-induced state change.

Verification
REQ-024 SHALL be verified: D=4, reset released, left_raw 0->1 before edge N and held -> left = 1, chg = 1 after edge N+6; right stays 0.
REQ-025 SHALL be verified: D=4, left_raw high for 3 cycles then low -> left, right, chg stay 0 throughout.
REQ-026 SHALL be verified: in LEFT, left_raw 1->0 and right_raw 0->1 together -> one cycle IDLE (left = right = 0, chg = 1), then RIGHT (right = 1, chg = 1 again).
REQ-027 SHALL be verified: in IDLE, both raw inputs 0->1 together -> left = right = 1 together after edge N+6; chg = 1 one cycle.
REQ-028 SHALL be verified: in HAZARD, reset pulsed low for 15 ns between edges -> left = right = chg = 0 asynchronously, counters cleared, outputs return to 1 only after a full REQ-020 latency.
REQ-029 SHALL be verified: raw input bouncing 0/1 every cycle for 20 cycles then held 1 -> single clean 0->1 transition on the output DEBOUNCE_CYCLES+2 edges after the final settle, exactly one chg pulse.
